// File: rtl/l2_host_mem_bridge_pkg.sv
// Shared types and line/beat sizing helpers for the L2-to-host OBI bridge.
package e_gpu_l2_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RSP   = 2'd3
    } state_e;

    localparam int LINE_WIDTH_DFLT = 128;
    localparam int BEATS           = LINE_WIDTH_DFLT / 32;
    localparam int BEAT_W          = $clog2(BEATS);

    function automatic int beats_of(input int line_width);
        return line_width / 32;
    endfunction

    function automatic int beat_w_of(input int line_width);
        return $clog2(line_width / 32);
    endfunction

endpackage

// File: rtl/l2_host_mem_bridge_if.sv
// L2 line-side request/response bundle and host OBI bundle used by the bridge.
interface l2_host_mem_bridge_if #(
    parameter int LINE_WIDTH = 128,
    parameter int ADDR_WIDTH = 28,
    parameter int TAG_WIDTH  = 8
);
    logic                    mem_req_valid;
    logic                    mem_req_rw;
    logic [LINE_WIDTH/8-1:0] mem_req_byteen;
    logic [ADDR_WIDTH-1:0]   mem_req_addr;
    logic [LINE_WIDTH-1:0]   mem_req_data;
    logic [TAG_WIDTH-1:0]    mem_req_tag;
    logic                    mem_req_ready;
    logic                    mem_rsp_valid;
    logic [LINE_WIDTH-1:0]   mem_rsp_data;
    logic [TAG_WIDTH-1:0]    mem_rsp_tag;
    logic                    mem_rsp_ready;

    modport master (
        output mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr,
               mem_req_data, mem_req_tag, mem_rsp_ready,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_tag
    );

    modport slave (
        input  mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr,
               mem_req_data, mem_req_tag, mem_rsp_ready,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_tag
    );
endinterface

interface l2_host_obi_if;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/l2_host_mem_bridge.sv
// Splits one L2 line request into sequential 32-bit OBI beats and reassembles read lines.
// Build option E_GPU_L2_BRIDGE_SKIP_EMPTY_BEATS_EN: write beats with an all-zero byte-enable slice are not issued.
module l2_host_mem_bridge
    import e_gpu_l2_bridge_pkg::*;
#(
    parameter int LINE_WIDTH = 128,
    parameter int ADDR_WIDTH = 28,
    parameter int TAG_WIDTH  = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    l2_host_mem_bridge_if.slave  mem,
    l2_host_obi_if.master        obi
);
    localparam int NBEATS = beats_of(LINE_WIDTH);
    localparam int NBW    = beat_w_of(LINE_WIDTH);
    localparam int BEW    = LINE_WIDTH / 8;

    state_e                state_q, state_d;
    logic [NBW-1:0]        beat_q, beat_d;
    logic                  rw_q, rw_d;
    logic [BEW-1:0]        byteen_q, byteen_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] line_q, line_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;
    logic [NBW-1:0]        nxt_beat;
    logic                  last_beat;
    logic                  issue;

`ifdef E_GPU_L2_BRIDGE_SKIP_EMPTY_BEATS_EN
    localparam logic [NBW:0] NO_BEAT = (NBW+1)'(NBEATS);
    logic [NBW:0] live_first, live_nxt;

    // Returns the first beat at or after 'from' with a non-zero byte-enable slice, NO_BEAT if none.
    function automatic logic [NBW:0] first_live_beat(input logic [BEW-1:0] be, input int from);
        logic [NBW:0] r;
        r = NO_BEAT;
        for (int b = NBEATS - 1; b >= 0; b--) begin
            if (b >= from && be[4*b +: 4] != 4'h0) r = (NBW+1)'(b);
        end
        return r;
    endfunction
`endif

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        rw_d      = rw_q;
        byteen_d  = byteen_q;
        addr_d    = addr_q;
        line_d    = line_q;
        tag_d     = tag_q;
        nxt_beat  = beat_q + NBW'(1);
        last_beat = (beat_q == NBW'(NBEATS - 1));
`ifdef E_GPU_L2_BRIDGE_SKIP_EMPTY_BEATS_EN
        live_first = first_live_beat(mem.mem_req_byteen, 0);
        live_nxt   = first_live_beat(byteen_q, int'(beat_q) + 1);
        if (rw_q) begin
            nxt_beat  = live_nxt[NBW-1:0];
            last_beat = (live_nxt == NO_BEAT);
        end
`endif
        case (state_q)
            IDLE: begin
                if (mem.mem_req_valid) begin
                    rw_d     = mem.mem_req_rw;
                    byteen_d = mem.mem_req_byteen;
                    addr_d   = mem.mem_req_addr;
                    line_d   = mem.mem_req_data;
                    tag_d    = mem.mem_req_tag;
                    beat_d   = '0;
                    state_d  = ISSUE;
`ifdef E_GPU_L2_BRIDGE_SKIP_EMPTY_BEATS_EN
                    if (mem.mem_req_rw) begin
                        if (live_first == NO_BEAT) state_d = IDLE;
                        else beat_d = live_first[NBW-1:0];
                    end
`endif
                end
            end
            ISSUE: begin
                if (obi.gnt) state_d = WAIT;
            end
            WAIT: begin
                if (obi.rvalid) begin
                    // Read words land in the same line register that held the write data.
                    if (!rw_q) line_d[32*beat_q +: 32] = obi.rdata;
                    if (last_beat) begin
                        state_d = rw_q ? IDLE : RSP;
                    end else begin
                        beat_d  = nxt_beat;
                        state_d = ISSUE;
                    end
                end
            end
            RSP: begin
                if (mem.mem_rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // Payload registers carry no reset; every output that exposes them is gated by state.
    always_ff @(posedge clk_i) begin
        rw_q     <= rw_d;
        byteen_q <= byteen_d;
        addr_q   <= addr_d;
        line_q   <= line_d;
        tag_q    <= tag_d;
    end

    assign issue             = (state_q == ISSUE);
    assign mem.mem_req_ready = (state_q == IDLE);
    assign mem.mem_rsp_valid = (state_q == RSP);
    assign mem.mem_rsp_data  = (state_q == RSP) ? line_q : '0;
    assign mem.mem_rsp_tag   = (state_q == RSP) ? tag_q : '0;

    assign obi.req   = issue;
    assign obi.addr  = issue ? 32'({addr_q, beat_q, 2'b00}) : 32'h0;
    assign obi.we    = issue & rw_q;
    assign obi.be    = !issue ? 4'h0 : (rw_q ? byteen_q[4*beat_q +: 4] : 4'hF);
    assign obi.wdata = (issue & rw_q) ? line_q[32*beat_q +: 32] : 32'h0;

endmodule

// File: tb/tb_l2_host_mem_bridge.sv
// Randomized bench for l2_host_mem_bridge with a transaction-level reference model and OBI responder.
module tb_l2_host_mem_bridge;
    localparam int LW = 128;
    localparam int AW = 28;
    localparam int TW = 8;
    localparam int NB = LW / 32;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } beat_t;

    typedef struct packed {
        logic [LW-1:0] data;
        logic [TW-1:0] tag;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    l2_host_mem_bridge_if #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)) mif ();
    l2_host_obi_if oif ();

    l2_host_mem_bridge #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .mem    (mif),
        .obi    (oif)
    );

    beat_t exp_beats[$];
    beat_t glog[$];
    rsp_t  exp_rsp[$];
    int    total = 0;
    int    bad   = 0;

    int    gd = 0, rd = 0, gcnt = 0, rcnt = 0;
    bit    rnd_mode = 0, lit_mode = 0, spur_en = 0, pend = 0;
    logic [31:0] paddr = '0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        if (lit_mode) return 32'(a[3:2]) + 32'd1;
        return (a * 32'h9E3779B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic int pick(input int d);
        return rnd_mode ? int'($urandom_range(0, 3)) : d;
    endfunction

    function automatic logic [207:0] out_vec();
        return {mif.mem_req_ready, mif.mem_rsp_valid, mif.mem_rsp_data, mif.mem_rsp_tag,
                oif.req, oif.addr, oif.we, oif.be, oif.wdata};
    endfunction

    // Reference model: what beats must appear on OBI and what line must come back.
    task automatic model_push(input logic rw, input logic [15:0] be, input logic [AW-1:0] addr,
                              input logic [LW-1:0] data, input logic [TW-1:0] tag);
        beat_t b;
        rsp_t  r;
        r.tag  = tag;
        r.data = '0;
        for (int k = 0; k < NB; k++) begin
            b.addr  = 32'(addr) * 32'd16 + 32'(4 * k);
            b.we    = rw;
            b.be    = rw ? be[4*k +: 4] : 4'hF;
            b.wdata = rw ? data[32*k +: 32] : 32'h0;
`ifdef E_GPU_L2_BRIDGE_SKIP_EMPTY_BEATS_EN
            if (rw && b.be == 4'h0) continue;
`endif
            exp_beats.push_back(b);
            r.data[32*k +: 32] = rdata_of(b.addr);
        end
        if (!rw) exp_rsp.push_back(r);
    endtask

    // OBI slave: grants after gd cycles, returns rdata rd cycles after the grant cycle.
    initial begin
        oif.gnt = 1'b0; oif.rvalid = 1'b0; oif.rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            oif.gnt = 1'b0;
            oif.rvalid = 1'b0;
            oif.rdata = $urandom;
            if (!rst_n) begin
                pend = 0;
                gcnt = gd;
            end else begin
                if (pend) begin
                    if (rcnt == 0) begin
                        oif.rvalid = 1'b1;
                        oif.rdata  = rdata_of(paddr);
                        pend = 0;
                    end else rcnt--;
                end else if (oif.req) begin
                    if (gcnt == 0) begin
                        oif.gnt = 1'b1;
                        paddr = oif.addr;
                        pend = 1;
                        rcnt = pick(rd);
                        gcnt = pick(gd);
                    end else gcnt--;
                end
                if (spur_en && !pend && !oif.gnt && !oif.rvalid && $urandom_range(0, 7) == 0)
                    oif.rvalid = 1'b1;
            end
        end
    end

    // Compare process: every cycle the outputs carry a beat or a response.
    always @(negedge clk) begin
        beat_t e, a;
        if (rst_n) begin
            if (oif.req) begin
                a = '{oif.addr, oif.we, oif.be, oif.wdata};
                if (exp_beats.size() == 0) chk("obi_unexpected_req", {a}, 0);
                else begin
                    e = exp_beats[0];
                    chk("obi_beat", {a.addr, a.we, a.be, e.we ? a.wdata : 32'h0},
                                    {e.addr, e.we, e.be, e.wdata});
                    if (oif.gnt) begin
                        glog.push_back(a);
                        void'(exp_beats.pop_front());
                    end
                end
            end
            if (mif.mem_rsp_valid) begin
                if (exp_rsp.size() == 0) chk("rsp_unexpected", {mif.mem_rsp_data, mif.mem_rsp_tag}, 0);
                else begin
                    chk("rsp_line", {mif.mem_rsp_data, mif.mem_rsp_tag}, exp_rsp[0]);
                    chk("rsp_blocks_req", {mif.mem_req_ready, oif.req}, 2'b00);
                    if (mif.mem_rsp_ready) void'(exp_rsp.pop_front());
                end
            end
        end
    end

    task automatic set_delays(input int g, input int r);
        gd = g; rd = r; gcnt = g;
    endtask

    task automatic run_txn(input logic rw, input logic [15:0] be, input logic [AW-1:0] addr,
                           input logic [LW-1:0] data, input logic [TW-1:0] tag, input int hold,
                           output int lat, output rsp_t rsp);
        int n;
        lat = 0;
        rsp = '0;
        model_push(rw, be, addr, data, tag);
        @(posedge clk);
        #1;
        mif.mem_req_valid = 1'b1; mif.mem_req_rw = rw; mif.mem_req_byteen = be;
        mif.mem_req_addr = addr; mif.mem_req_data = data; mif.mem_req_tag = tag;
        n = 0;
        @(negedge clk);
        while (!mif.mem_req_ready && n < 300) begin n++; @(negedge clk); end
        if (!mif.mem_req_ready) begin
            chk("accept_timeout", 1, 0);
            mif.mem_req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        mif.mem_req_valid = 1'b0;
        mif.mem_req_data = {4{$urandom}};
        mif.mem_req_byteen = 16'($urandom);
        lat = 1;
        n = 0;
        @(negedge clk);
        while (!(rw ? mif.mem_req_ready : mif.mem_rsp_valid) && n < 600) begin
            @(posedge clk);
            lat++; n++;
            @(negedge clk);
        end
        if (!(rw ? mif.mem_req_ready : mif.mem_rsp_valid)) begin
            chk("done_timeout", 1, 0);
            return;
        end
        if (!rw) begin
            rsp = '{mif.mem_rsp_data, mif.mem_rsp_tag};
            @(posedge clk);
            repeat (hold) @(posedge clk);
            #1;
            mif.mem_rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            mif.mem_rsp_ready = 1'b0;
        end
        chk("beats_left", 32'(exp_beats.size()), 0);
    endtask

    initial begin
        int   lat;
        rsp_t rsp;
        int   n;
        logic rw;
        logic [15:0] be;
        mif.mem_req_valid = 1'b0; mif.mem_req_rw = 1'b0; mif.mem_req_byteen = '0;
        mif.mem_req_addr = '0; mif.mem_req_data = '0; mif.mem_req_tag = '0;
        mif.mem_rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", out_vec(), {1'b1, 207'b0});
        #1 rst_n = 1'b1;

        // Directed read: rdata 1,2,3,4 at 0x100..0x10C.
        lit_mode = 1; set_delays(0, 0); glog.delete();
        run_txn(1'b0, 16'h0, 28'h0000010, {4{$urandom}}, 8'h5C, 0, lat, rsp);
        chk("rd_latency", lat, 9);
        chk("rd_line", rsp, {128'h00000004_00000003_00000002_00000001, 8'h5C});
        chk("rd_beats", glog.size(), 4);
        if (glog.size() == 4)
            for (int i = 0; i < 4; i++) chk($sformatf("rd_addr%0d", i), glog[i].addr, 32'h100 + 32'(4 * i));

        // Directed full write.
        lit_mode = 0; glog.delete();
        run_txn(1'b1, 16'hFFFF, 28'h0000011, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 8'h21, 0, lat, rsp);
        chk("wr_latency", lat, 9);
        chk("wr_beats", glog.size(), 4);
        if (glog.size() == 4) begin
            chk("wr_b0", glog[0], {32'h110, 1'b1, 4'hF, 32'hAAAAAAAA});
            chk("wr_b1", glog[1], {32'h114, 1'b1, 4'hF, 32'hBBBBBBBB});
            chk("wr_b2", glog[2], {32'h118, 1'b1, 4'hF, 32'hCCCCCCCC});
            chk("wr_b3", glog[3], {32'h11C, 1'b1, 4'hF, 32'hDDDDDDDD});
        end

        // Sparse and empty byte enables.
        glog.delete();
        run_txn(1'b1, 16'h00F0, 28'h0000020, {4{$urandom}}, 8'h33, 0, lat, rsp);
`ifdef E_GPU_L2_BRIDGE_SKIP_EMPTY_BEATS_EN
        chk("sparse_beats", glog.size(), 1);
        chk("sparse_latency", lat, 3);
        if (glog.size() == 1) chk("sparse_b", {glog[0].addr, glog[0].be}, {32'h204, 4'hF});
        glog.delete();
        run_txn(1'b1, 16'h0000, 28'h0000030, {4{$urandom}}, 8'h44, 0, lat, rsp);
        chk("empty_beats", glog.size(), 0);
        chk("empty_latency", lat, 1);
`else
        chk("sparse_beats", glog.size(), 4);
        chk("sparse_latency", lat, 9);
        if (glog.size() == 4)
            chk("sparse_be", {glog[0].be, glog[1].be, glog[2].be, glog[3].be}, 16'h0F00);
        glog.delete();
        run_txn(1'b1, 16'h0000, 28'h0000030, {4{$urandom}}, 8'h44, 0, lat, rsp);
        chk("empty_beats", glog.size(), 4);
        chk("empty_latency", lat, 9);
`endif

        // Slow grant and slow read data.
        set_delays(3, 5); spur_en = 1;
        run_txn(1'b0, 16'h0, 28'($urandom), {4{$urandom}}, 8'h66, 0, lat, rsp);
        chk("slow_rd_latency", lat, 41);
        run_txn(1'b1, 16'hFFFF, 28'($urandom), {4{$urandom}}, 8'h67, 0, lat, rsp);
        chk("slow_wr_latency", lat, 41);

        // Response back-pressure.
        set_delays(0, 0);
        run_txn(1'b0, 16'h0, 28'($urandom), {4{$urandom}}, 8'h77, 10, lat, rsp);

        // Reset during beat 2 of a read.
        model_push(1'b0, 16'h0, 28'h0000040, '0, 8'h88);
        @(posedge clk);
        #1;
        mif.mem_req_valid = 1'b1; mif.mem_req_rw = 1'b0; mif.mem_req_addr = 28'h0000040; mif.mem_req_tag = 8'h88;
        @(posedge clk);
        #1;
        mif.mem_req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!(oif.req && oif.addr[3:2] == 2'd2) && n < 100) begin n++; @(negedge clk); end
        chk("rst_reached_beat2", {oif.req, oif.addr}, {1'b1, 32'h408});
        rst_n = 1'b0;
        exp_beats.delete(); exp_rsp.delete();
        #1;
        chk("rst_async_outputs", out_vec(), {1'b1, 207'b0});
        @(posedge clk);
        #1;
        chk("rst_next_outputs", out_vec(), {1'b1, 207'b0});
        #1 rst_n = 1'b1;
        run_txn(1'b0, 16'h0, 28'h0000041, '0, 8'h99, 0, lat, rsp);
        chk("post_rst_latency", lat, 9);

        // Randomized traffic.
        rnd_mode = 1;
        for (int t = 0; t < 40; t++) begin
            rw = 1'($urandom_range(0, 1));
            for (int k = 0; k < NB; k++) begin
                n = int'($urandom_range(0, 3));
                be[4*k +: 4] = (n == 0) ? 4'h0 : (n == 1) ? 4'hF : 4'($urandom);
            end
            run_txn(rw, be, 28'($urandom), {4{$urandom}}, 8'($urandom), int'($urandom_range(0, 3)), lat, rsp);
        end

        repeat (5) @(posedge clk);
        chk("end_queues", {32'(exp_beats.size()), 32'(exp_rsp.size())}, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
